match_timer_ctrl: RTL and testbench
===================================

MATCH_TIMER_CTRL -- requirements
Module: match_timer_ctrl

Interface
REQ-001 SHALL have parameter MATCH_SECONDS, default 120, match length in seconds (legal range 1..599).
REQ-002 SHALL have parameter GOAL_HOLD_SECONDS, default 3, freeze time after a goal in seconds (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port one_sec, input, 1 bit: one-clk-wide tick from the one-second counter.
REQ-006 SHALL have port start, input, 1 bit: one-clk pulse that starts or restarts a match.
REQ-007 SHALL have port pause, input, 1 bit: one-clk pulse that toggles pause.
REQ-008 SHALL have port goal, input, 1 bit: one-clk pulse, goal scored.
REQ-009 SHALL have port min_digit, output, 4 bits: BCD minutes remaining.
REQ-010 SHALL have port sec_tens, output, 4 bits: BCD tens of seconds remaining (0..5).
REQ-011 SHALL have port sec_ones, output, 4 bits: BCD units of seconds remaining (0..9).
REQ-012 SHALL have port game_active, output, 1 bit: high only in RUN; gates player and ball motion.
REQ-013 SHALL have port last_ten, output, 1 bit: high in RUN or PAUSE while remaining time is 10 s or less and not zero.
REQ-014 SHALL have port time_up, output, 1 bit: one-clk pulse on entry to OVER.
REQ-015 SHALL have port game_over, output, 1 bit: high while in OVER.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSE, HOLD, OVER; all outputs registered.
REQ-017 SHALL keep remaining time as a registered BCD down-counter:
- sec_ones borrows 0->9 from sec_tens.
- sec_tens borrows 0->5 from min_digit.
- The counter never wraps below 0:00.
REQ-018 SHALL load the counter with MATCH_SECONDS converted to BCD, using constants computed at elaboration, on every reload.
REQ-019 IDLE: on start, SHALL reload the counter and enter RUN on the next edge; one_sec, pause and goal are ignored.
REQ-020 RUN: SHALL decrement the counter by exactly 1 on each cycle with one_sec=1.
REQ-021 RUN: a tick that takes the counter from 0:01 to 0:00 SHALL enter OVER and assert time_up for exactly that one cycle.
REQ-022 RUN: on goal, SHALL enter HOLD and load a 4-bit hold counter with GOAL_HOLD_SECONDS.
REQ-023 RUN: on pause, SHALL enter PAUSE.
REQ-024 RUN: on start, SHALL reload the counter and remain in RUN.
REQ-025 RUN priority for simultaneous inputs: start > expiry to OVER > goal > pause; a tick in the same cycle as goal or pause SHALL still decrement.
REQ-026 PAUSE: SHALL freeze the counter and ignore one_sec and goal; pause returns to RUN; start reloads and enters RUN.
REQ-027 HOLD: SHALL freeze the match counter; each one_sec decrements the hold counter; reaching 0 enters RUN on the same edge.
REQ-028 HOLD: SHALL ignore pause and goal; start reloads, clears the hold counter and enters RUN.
REQ-029 OVER: SHALL hold the counter at 0:00; start reloads and enters RUN; all other inputs ignored.
REQ-030 game_active SHALL be 0 in IDLE, PAUSE, HOLD and OVER.
REQ-031 Input pulses SHALL be sampled once per clk with no internal edge detection; a held level is treated as a pulse on every cycle.

Reset
REQ-032 Assertion of resetN SHALL immediately force:
- state IDLE;
- counter = MATCH_SECONDS in BCD;
- hold counter 0;
- game_active, last_ten, time_up, game_over all 0.
REQ-033 Reset asserted mid-match (any state) SHALL discard remaining time and hold count; after release, only start leaves IDLE.

Verification
REQ-034 Start and run with MATCH_SECONDS=5: start, then 5 ticks -> digits 0:05,0:04,...,0:00; time_up is one cycle on the 5th tick; game_over stays high; game_active drops.
REQ-035 BCD borrow with MATCH_SECONDS=120: start, then 1 tick -> 1:59 (min=1, tens=5, ones=9); 50 more ticks -> 1:09; 10 more ticks -> 0:59; last_ten first high at 0:10.
REQ-036 Goal hold with GOAL_HOLD_SECONDS=3 at 1:30: goal -> HOLD and game_active=0; 2 ticks -> still 1:30 and HOLD; 3rd tick -> RUN; next tick -> 1:29.
REQ-037 Pause: pause at 0:45, then 4 ticks -> 0:45 held; pause -> RUN; tick -> 0:44; goal while paused produces no HOLD.
REQ-038 Simultaneous events: at 0:01, tick+goal in the same cycle -> OVER with time_up, no HOLD; at 0:20, start+tick in the same cycle -> 2:00 reload, no decrement.
REQ-039 Reset mid-operation: resetN low during HOLD at 0:33 -> outputs 2:00 and IDLE asynchronously; after release, ticks and goal cause no change until start.

Source files
------------

// File: rtl/match_timer_ctrl.sv
// Match timer controller: BCD countdown of the match clock with run, pause,
// post-goal hold and game-over handling for the game core.
module match_timer_ctrl #(
    parameter int MATCH_SECONDS     = 120,
    parameter int GOAL_HOLD_SECONDS = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       one_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       goal,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       game_active,
    output logic       last_ten,
    output logic       time_up,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, RUN, PAUSE, HOLD, OVER} stateT;

    localparam logic [3:0]  INIT_MIN   = 4'(MATCH_SECONDS / 60);
    localparam logic [3:0]  INIT_TENS  = 4'((MATCH_SECONDS % 60) / 10);
    localparam logic [3:0]  INIT_ONES  = 4'(MATCH_SECONDS % 10);
    localparam logic [11:0] LOAD_COUNT = {INIT_MIN, INIT_TENS, INIT_ONES};
    localparam logic [3:0]  HOLD_LOAD  = 4'(GOAL_HOLD_SECONDS);

    stateT       state, nextState;
    logic [11:0] count, nextCount, decCount;
    logic [3:0]  holdCount, nextHold;

    assign min_digit = count[11:8];
    assign sec_tens  = count[7:4];
    assign sec_ones  = count[3:0];

    // One-second BCD decrement with borrows; saturates at 0:00.
    always_comb begin
        decCount = count;
        if (count[3:0] != 4'd0) begin
            decCount[3:0] = count[3:0] - 4'd1;
        end else if (count[7:4] != 4'd0) begin
            decCount[7:4] = count[7:4] - 4'd1;
            decCount[3:0] = 4'd9;
        end else if (count[11:8] != 4'd0) begin
            decCount[11:8] = count[11:8] - 4'd1;
            decCount[7:4]  = 4'd5;
            decCount[3:0]  = 4'd9;
        end
    end

    always_comb begin
        nextState = state;
        nextCount = count;
        nextHold  = holdCount;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextCount = LOAD_COUNT;
                    nextState = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    nextCount = LOAD_COUNT;
                end else begin
                    if (one_sec) nextCount = decCount;
                    if (one_sec && count == 12'h001) begin
                        nextState = OVER;
                    end else if (goal) begin
                        nextState = HOLD;
                        nextHold  = HOLD_LOAD;
                    end else if (pause) begin
                        nextState = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (start) begin
                    nextCount = LOAD_COUNT;
                    nextState = RUN;
                end else if (pause) begin
                    nextState = RUN;
                end
            end
            HOLD: begin
                if (start) begin
                    nextCount = LOAD_COUNT;
                    nextHold  = 4'd0;
                    nextState = RUN;
                end else if (one_sec) begin
                    // A hold count of 1 (or a stray 0) expires on this tick.
                    if (holdCount <= 4'd1) begin
                        nextHold  = 4'd0;
                        nextState = RUN;
                    end else begin
                        nextHold = holdCount - 4'd1;
                    end
                end
            end
            OVER: begin
                nextCount = 12'h000;
                if (start) begin
                    nextCount = LOAD_COUNT;
                    nextState = RUN;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Status flags are derived from next-state values so they line up with
    // the registered counter on the same edge. Packed BCD orders like binary.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            count       <= LOAD_COUNT;
            holdCount   <= 4'd0;
            game_active <= 1'b0;
            last_ten    <= 1'b0;
            time_up     <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= nextState;
            count       <= nextCount;
            holdCount   <= nextHold;
            game_active <= (nextState == RUN);
            last_ten    <= ((nextState == RUN) || (nextState == PAUSE)) &&
                           (nextCount != 12'h000) && (nextCount <= 12'h010);
            time_up     <= (state == RUN) && (nextState == OVER);
            game_over   <= (nextState == OVER);
        end
    end

endmodule

// File: tb/tb_match_timer_ctrl.sv
// Directed bench for match_timer_ctrl: a vector table for single-cycle
// behaviour plus hand-written sequences for borrows, holds, pause and reset.
module tb_match_timer_ctrl;

    logic       clk;
    logic       resetN;
    logic       oneSec, start, pause, goal;
    logic [3:0] minDigit, secTens, secOnes;
    logic       gameActive, lastTen, timeUp, gameOver;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       start, pause, goal, oneSec;
        logic [3:0] expMin, expTens, expOnes;
        logic       expActive, expLastTen, expTimeUp, expOver;
    } vectorT;

    vectorT vecs[16];

    match_timer_ctrl #(.MATCH_SECONDS(120), .GOAL_HOLD_SECONDS(3)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .one_sec    (oneSec),
        .start      (start),
        .pause      (pause),
        .goal       (goal),
        .min_digit  (minDigit),
        .sec_tens   (secTens),
        .sec_ones   (secOnes),
        .game_active(gameActive),
        .last_ten   (lastTen),
        .time_up    (timeUp),
        .game_over  (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vectorT mkVec(input logic s, p, g, t,
                                     input logic [3:0] m, te, o,
                                     input logic a, l, tu, ov);
        vectorT v;
        v.start = s; v.pause = p; v.goal = g; v.oneSec = t;
        v.expMin = m; v.expTens = te; v.expOnes = o;
        v.expActive = a; v.expLastTen = l; v.expTimeUp = tu; v.expOver = ov;
        return v;
    endfunction

    // Drive one cycle of inputs, sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic s, p, g, t);
        @(negedge clk);
        start = s; pause = p; goal = g; oneSec = t;
        @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; goal = 1'b0; oneSec = 1'b0;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string name,
                               input logic [3:0] m, te, o,
                               input logic a, l, tu, ov);
        logic [15:0] act, exp;
        act = {minDigit, secTens, secOnes, gameActive, lastTen, timeUp, gameOver};
        exp = {m, te, o, a, l, tu, ov};
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h:%h%h act=%b last=%b up=%b over=%b, want %h:%h%h act=%b last=%b up=%b over=%b",
                     name, minDigit, secTens, secOnes, gameActive, lastTen, timeUp, gameOver,
                     m, te, o, a, l, tu, ov);
        end
    endtask

    initial begin
        // start pause goal tick | min tens ones | active lastTen timeUp over
        vecs[0]  = mkVec(1,0,0,0, 4'd2,4'd0,4'd0, 1,0,0,0);
        vecs[1]  = mkVec(0,0,0,1, 4'd1,4'd5,4'd9, 1,0,0,0);
        vecs[2]  = mkVec(0,0,1,0, 4'd1,4'd5,4'd9, 0,0,0,0);
        vecs[3]  = mkVec(0,0,0,1, 4'd1,4'd5,4'd9, 0,0,0,0);
        vecs[4]  = mkVec(0,1,0,0, 4'd1,4'd5,4'd9, 0,0,0,0);
        vecs[5]  = mkVec(0,0,0,1, 4'd1,4'd5,4'd9, 0,0,0,0);
        vecs[6]  = mkVec(0,0,0,1, 4'd1,4'd5,4'd9, 1,0,0,0);
        vecs[7]  = mkVec(0,1,0,1, 4'd1,4'd5,4'd8, 0,0,0,0);
        vecs[8]  = mkVec(0,0,0,1, 4'd1,4'd5,4'd8, 0,0,0,0);
        vecs[9]  = mkVec(0,0,1,0, 4'd1,4'd5,4'd8, 0,0,0,0);
        vecs[10] = mkVec(0,1,0,0, 4'd1,4'd5,4'd8, 1,0,0,0);
        vecs[11] = mkVec(0,0,1,1, 4'd1,4'd5,4'd7, 0,0,0,0);
        vecs[12] = mkVec(1,0,0,0, 4'd2,4'd0,4'd0, 1,0,0,0);
        vecs[13] = mkVec(1,0,0,1, 4'd2,4'd0,4'd0, 1,0,0,0);
        vecs[14] = mkVec(0,1,0,0, 4'd2,4'd0,4'd0, 0,0,0,0);
        vecs[15] = mkVec(1,0,0,0, 4'd2,4'd0,4'd0, 1,0,0,0);

        resetN = 1'b1; oneSec = 1'b0; start = 1'b0; pause = 1'b0; goal = 1'b0;
        #2 resetN = 1'b0;
        #5;
        checkOutput("resetState", 4'd2,4'd0,4'd0, 0,0,0,0);
        @(negedge clk) resetN = 1'b1;

        // Idle ignores everything but start.
        applyStimulus(0,1,1,1);
        checkOutput("idleIgnore", 4'd2,4'd0,4'd0, 0,0,0,0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].start, vecs[i].pause, vecs[i].goal, vecs[i].oneSec);
            checkOutput($sformatf("vec%0d", i), vecs[i].expMin, vecs[i].expTens,
                        vecs[i].expOnes, vecs[i].expActive, vecs[i].expLastTen,
                        vecs[i].expTimeUp, vecs[i].expOver);
        end

        // BCD borrows, last-ten window and expiry beating a goal.
        tickN(1);  checkOutput("borrow159", 4'd1,4'd5,4'd9, 1,0,0,0);
        tickN(50); checkOutput("borrow109", 4'd1,4'd0,4'd9, 1,0,0,0);
        tickN(10); checkOutput("borrow059", 4'd0,4'd5,4'd9, 1,0,0,0);
        tickN(48); checkOutput("at011", 4'd0,4'd1,4'd1, 1,0,0,0);
        tickN(1);  checkOutput("at010", 4'd0,4'd1,4'd0, 1,1,0,0);
        applyStimulus(0,1,0,0); checkOutput("pause010", 4'd0,4'd1,4'd0, 0,1,0,0);
        tickN(3);  checkOutput("pausedTicks", 4'd0,4'd1,4'd0, 0,1,0,0);
        applyStimulus(0,1,0,0); checkOutput("resume010", 4'd0,4'd1,4'd0, 1,1,0,0);
        tickN(9);  checkOutput("at001", 4'd0,4'd0,4'd1, 1,1,0,0);
        applyStimulus(0,0,1,1); checkOutput("expiryGoal", 4'd0,4'd0,4'd0, 0,0,1,1);
        applyStimulus(0,0,0,0); checkOutput("overHold", 4'd0,4'd0,4'd0, 0,0,0,1);
        applyStimulus(0,1,1,1); checkOutput("overIgnore", 4'd0,4'd0,4'd0, 0,0,0,1);
        applyStimulus(1,0,0,0); checkOutput("overRestart", 4'd2,4'd0,4'd0, 1,0,0,0);

        // Goal hold at 1:30 lasts three ticks.
        tickN(30); checkOutput("at130", 4'd1,4'd3,4'd0, 1,0,0,0);
        applyStimulus(0,0,1,0); checkOutput("goalHold", 4'd1,4'd3,4'd0, 0,0,0,0);
        tickN(2);  checkOutput("holdTwo", 4'd1,4'd3,4'd0, 0,0,0,0);
        tickN(1);  checkOutput("holdDone", 4'd1,4'd3,4'd0, 1,0,0,0);
        tickN(1);  checkOutput("after129", 4'd1,4'd2,4'd9, 1,0,0,0);

        // Asynchronous reset in HOLD, then only start leaves IDLE.
        tickN(56); checkOutput("at033", 4'd0,4'd3,4'd3, 1,0,0,0);
        applyStimulus(0,0,1,0); checkOutput("hold033", 4'd0,4'd3,4'd3, 0,0,0,0);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1 checkOutput("asyncReset", 4'd2,4'd0,4'd0, 0,0,0,0);
        @(negedge clk) resetN = 1'b1;
        applyStimulus(0,0,0,1); checkOutput("postRstTick", 4'd2,4'd0,4'd0, 0,0,0,0);
        applyStimulus(0,0,1,1); checkOutput("postRstGoal", 4'd2,4'd0,4'd0, 0,0,0,0);
        tickN(2);  checkOutput("postRstTicks", 4'd2,4'd0,4'd0, 0,0,0,0);
        applyStimulus(1,0,0,0); checkOutput("postRstStart", 4'd2,4'd0,4'd0, 1,0,0,0);

        // Start wins over a simultaneous tick at 0:20.
        tickN(100); checkOutput("at020", 4'd0,4'd2,4'd0, 1,0,0,0);
        applyStimulus(1,0,0,1); checkOutput("startTick020", 4'd2,4'd0,4'd0, 1,0,0,0);

        // Pause at 0:45; a goal while paused must not start a hold.
        tickN(75); checkOutput("at045", 4'd0,4'd4,4'd5, 1,0,0,0);
        applyStimulus(0,1,0,0); checkOutput("pause045", 4'd0,4'd4,4'd5, 0,0,0,0);
        tickN(4);  checkOutput("paused045", 4'd0,4'd4,4'd5, 0,0,0,0);
        applyStimulus(0,0,1,0); checkOutput("pausedGoal", 4'd0,4'd4,4'd5, 0,0,0,0);
        applyStimulus(0,1,0,0); checkOutput("resume045", 4'd0,4'd4,4'd5, 1,0,0,0);
        tickN(1);  checkOutput("at044", 4'd0,4'd4,4'd4, 1,0,0,0);

        // Plain tick expiry, time_up lasts one cycle.
        tickN(43); checkOutput("at001b", 4'd0,4'd0,4'd1, 1,1,0,0);
        tickN(1);  checkOutput("expiry", 4'd0,4'd0,4'd0, 0,0,1,1);
        applyStimulus(0,0,0,0); checkOutput("timeUpPulse", 4'd0,4'd0,4'd0, 0,0,0,1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
